storage_exc_entry: RTL and testbench

//   Responder for the DSI/ISI storage-exception request flags. Takes a pending request
//   and sequences exception entry: stall and drain the pipeline, then write SRR0/SRR1
//   (plus DAR/DSISR for DSI), update the MSR, and redirect the PC to the vector.

---
 rtl/storage_exc_entry.sv | 141 ++++++++++++++
 tb/tb_storage_exc_entry.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/storage_exc_entry.sv
// Storage-exception entry sequencer: takes a pending DSI/ISI request, drains the pipeline,
// writes SRR0/SRR1 (and DAR/DSISR for DSI), updates the MSR, redirects the PC and acks the request.
module storage_exc_entry #(
    parameter logic [31:0] DSI_VECTOR = 32'h0000_0300,
    parameter logic [31:0] ISI_VECTOR = 32'h0000_0400,
    parameter logic [31:0] MSR_CLR    = 32'h0000_C030
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dsi,
    input  logic        isi,
    input  logic [31:0] pc_fault,
    input  logic [31:0] ea_fault,
    input  logic        is_store,
    input  logic [31:0] msr_in,
    input  logic        pipe_idle,
    output logic        stall_req,
    output logic [31:0] srr0,
    output logic [31:0] srr1,
    output logic [31:0] dar,
    output logic [31:0] dsisr,
    output logic        srr_we,
    output logic        dar_we,
    output logic [31:0] msr_out,
    output logic        msr_we,
    output logic [31:0] npc,
    output logic        npc_we,
    output logic        dsi_ack,
    output logic        isi_ack,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        SAVE  = 3'd2,
        VECT  = 3'd3,
        ACK   = 3'd4
    } state_t;

    localparam logic [31:0] DSISR_BASE  = 32'h0800_0000;
    localparam logic [31:0] DSISR_STORE = 32'h0200_0000;
    localparam logic [31:0] ISI_SRR1_KEEP = 32'h0000_FFFF;

    state_t      state_r;
    logic        kind_dsi_r;
    logic [31:0] pc_r;
    logic [31:0] ea_r;
    logic [31:0] msr_r;
    logic        store_r;

    // Entry FSM; each state's outputs are loaded on the edge that enters it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            kind_dsi_r <= 1'b0;
            pc_r       <= 32'h0000_0000;
            ea_r       <= 32'h0000_0000;
            msr_r      <= 32'h0000_0000;
            store_r    <= 1'b0;
            stall_req  <= 1'b0;
            srr0       <= 32'h0000_0000;
            srr1       <= 32'h0000_0000;
            dar        <= 32'h0000_0000;
            dsisr      <= 32'h0000_0000;
            srr_we     <= 1'b0;
            dar_we     <= 1'b0;
            msr_out    <= 32'h0000_0000;
            msr_we     <= 1'b0;
            npc        <= 32'h0000_0000;
            npc_we     <= 1'b0;
            dsi_ack    <= 1'b0;
            isi_ack    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            srr_we  <= 1'b0;
            dar_we  <= 1'b0;
            msr_we  <= 1'b0;
            npc_we  <= 1'b0;
            dsi_ack <= 1'b0;
            isi_ack <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (dsi || isi) begin
                        // DSI has priority; a simultaneous ISI stays pending upstream.
                        kind_dsi_r <= dsi;
                        pc_r       <= pc_fault;
                        ea_r       <= ea_fault;
                        msr_r      <= msr_in;
                        store_r    <= is_store;
                        stall_req  <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= DRAIN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DRAIN: begin
                    if (pipe_idle) begin
                        srr_we <= 1'b1;
                        srr0   <= pc_r;
                        if (kind_dsi_r) begin
                            srr1   <= msr_r;
                            dar    <= ea_r;
                            dsisr  <= store_r ? (DSISR_BASE | DSISR_STORE) : DSISR_BASE;
                            dar_we <= 1'b1;
                        end else begin
                            srr1 <= (msr_r & ISI_SRR1_KEEP) | DSISR_BASE;
                        end
                        state_r <= SAVE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                SAVE: begin
                    msr_out <= msr_r & ~MSR_CLR;
                    npc     <= kind_dsi_r ? DSI_VECTOR : ISI_VECTOR;
                    msr_we  <= 1'b1;
                    npc_we  <= 1'b1;
                    state_r <= VECT;
                end
                VECT: begin
                    dsi_ack <= kind_dsi_r;
                    isi_ack <= ~kind_dsi_r;
                    state_r <= ACK;
                end
                ACK: begin
                    stall_req <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    stall_req <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_storage_exc_entry.sv
// Directed bench for storage_exc_entry: DSI load/store, ISI, DSI+ISI priority,
// long drain and reset mid-sequence, with a requester model that clears flags on ack.
module tb_storage_exc_entry;

    logic        clk;
    logic        rst;
    logic        dsi;
    logic        isi;
    logic [31:0] pc_fault;
    logic [31:0] ea_fault;
    logic        is_store;
    logic [31:0] msr_in;
    logic        pipe_idle;
    logic        stall_req;
    logic [31:0] srr0;
    logic [31:0] srr1;
    logic [31:0] dar;
    logic [31:0] dsisr;
    logic        srr_we;
    logic        dar_we;
    logic [31:0] msr_out;
    logic        msr_we;
    logic [31:0] npc;
    logic        npc_we;
    logic        dsi_ack;
    logic        isi_ack;
    logic        busy;

    int tests_run;
    int tests_failed;

    storage_exc_entry dut (
        .clk       (clk),
        .rst       (rst),
        .dsi       (dsi),
        .isi       (isi),
        .pc_fault  (pc_fault),
        .ea_fault  (ea_fault),
        .is_store  (is_store),
        .msr_in    (msr_in),
        .pipe_idle (pipe_idle),
        .stall_req (stall_req),
        .srr0      (srr0),
        .srr1      (srr1),
        .dar       (dar),
        .dsisr     (dsisr),
        .srr_we    (srr_we),
        .dar_we    (dar_we),
        .msr_out   (msr_out),
        .msr_we    (msr_we),
        .npc       (npc),
        .npc_we    (npc_we),
        .dsi_ack   (dsi_ack),
        .isi_ack   (isi_ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; requester drops its flag at the edge that samples its ack.
    task automatic tick();
        logic da;
        logic ia;
        da = dsi_ack;
        ia = isi_ack;
        @(posedge clk);
        #1;
        if (da) dsi = 1'b0;
        if (ia) isi = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".stall"},  32'(stall_req), 32'd0);
        check_eq({tag, ".busy"},   32'(busy),      32'd0);
        check_eq({tag, ".srr0"},   srr0,           32'd0);
        check_eq({tag, ".srr1"},   srr1,           32'd0);
        check_eq({tag, ".dar"},    dar,            32'd0);
        check_eq({tag, ".dsisr"},  dsisr,          32'd0);
        check_eq({tag, ".msr"},    msr_out,        32'd0);
        check_eq({tag, ".npc"},    npc,            32'd0);
        check_eq({tag, ".strobes"}, 32'({srr_we, dar_we, msr_we, npc_we}), 32'd0);
        check_eq({tag, ".acks"},   32'({dsi_ack, isi_ack}), 32'd0);
    endtask

    // IDLE -> DRAIN edge
    task automatic start_seq(input string tag);
        tick();
        check_eq({tag, ".drain_busy"},  32'(busy),      32'd1);
        check_eq({tag, ".drain_stall"}, 32'(stall_req), 32'd1);
        check_eq({tag, ".drain_str"},   32'({srr_we, dar_we, msr_we, npc_we}), 32'd0);
    endtask

    // DRAIN (pipe_idle=1) -> SAVE -> VECT -> ACK -> IDLE, one check group per cycle
    task automatic finish_seq(input string tag, input logic k_dsi,
                              input logic [31:0] e_srr0, input logic [31:0] e_srr1,
                              input logic [31:0] e_dar, input logic [31:0] e_dsisr,
                              input logic [31:0] e_npc, input logic [31:0] e_msr);
        tick();
        check_eq({tag, ".save_srr_we"}, 32'(srr_we), 32'd1);
        check_eq({tag, ".save_dar_we"}, 32'(dar_we), 32'(k_dsi));
        check_eq({tag, ".save_vec_we"}, 32'({msr_we, npc_we}), 32'd0);
        check_eq({tag, ".srr0"},  srr0,  e_srr0);
        check_eq({tag, ".srr1"},  srr1,  e_srr1);
        check_eq({tag, ".dar"},   dar,   e_dar);
        check_eq({tag, ".dsisr"}, dsisr, e_dsisr);
        tick();
        check_eq({tag, ".vect_srr_we"}, 32'({srr_we, dar_we}), 32'd0);
        check_eq({tag, ".vect_we"},     32'({msr_we, npc_we}), 32'd3);
        check_eq({tag, ".npc"},     npc,     e_npc);
        check_eq({tag, ".msr_out"}, msr_out, e_msr);
        check_eq({tag, ".vect_ack"}, 32'({dsi_ack, isi_ack}), 32'd0);
        tick();
        check_eq({tag, ".ack"},       32'({dsi_ack, isi_ack}), 32'({k_dsi, ~k_dsi}));
        check_eq({tag, ".ack_we"},    32'({msr_we, npc_we}), 32'd0);
        check_eq({tag, ".ack_busy"},  32'({busy, stall_req}), 32'd3);
        tick();
        check_eq({tag, ".idle_busy"}, 32'({busy, stall_req}), 32'd0);
        check_eq({tag, ".idle_ack"},  32'({dsi_ack, isi_ack}), 32'd0);
        check_eq({tag, ".hold_srr0"}, srr0, e_srr0);
        check_eq({tag, ".hold_npc"},  npc,  e_npc);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        dsi       = 1'b0;
        isi       = 1'b0;
        pc_fault  = 32'h0;
        ea_fault  = 32'h0;
        is_store  = 1'b0;
        msr_in    = 32'h0;
        pipe_idle = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("idle");

        // DSI load
        dsi = 1'b1; pc_fault = 32'h100; ea_fault = 32'h2000; is_store = 1'b0;
        msr_in = 32'h1234_C0F0; pipe_idle = 1'b1;
        start_seq("dsi_ld");
        finish_seq("dsi_ld", 1'b1, 32'h100, 32'h1234_C0F0, 32'h2000, 32'h0800_0000,
                   32'h300, 32'h1234_00C0);
        check_eq("dsi_ld.flag_cleared", 32'(dsi), 32'd0);

        // DSI store
        dsi = 1'b1; pc_fault = 32'h204; ea_fault = 32'h3008; is_store = 1'b1;
        msr_in = 32'h0000_C032;
        start_seq("dsi_st");
        finish_seq("dsi_st", 1'b1, 32'h204, 32'h0000_C032, 32'h3008, 32'h0A00_0000,
                   32'h300, 32'h0000_0002);

        // ISI: DAR/DSISR keep the previous DSI values
        isi = 1'b1; pc_fault = 32'h408; ea_fault = 32'hDEAD_BEEF; is_store = 1'b1;
        msr_in = 32'hFFFF_4010;
        start_seq("isi");
        finish_seq("isi", 1'b0, 32'h408, 32'h0800_4010, 32'h3008, 32'h0A00_0000,
                   32'h400, 32'hFFFF_0000);

        // DSI and ISI together: DSI first, ISI picked up on the IDLE cycle after
        dsi = 1'b1; isi = 1'b1; pc_fault = 32'h500; ea_fault = 32'h6000; is_store = 1'b0;
        msr_in = 32'h0;
        start_seq("both_dsi");
        finish_seq("both_dsi", 1'b1, 32'h500, 32'h0, 32'h6000, 32'h0800_0000, 32'h300, 32'h0);
        check_eq("both.isi_pending", 32'(isi), 32'd1);
        pc_fault = 32'h504;
        start_seq("both_isi");
        finish_seq("both_isi", 1'b0, 32'h504, 32'h0800_0000, 32'h6000, 32'h0800_0000,
                   32'h400, 32'h0);

        // Long drain: no timeout, no strobes while pipe_idle is low
        dsi = 1'b1; pc_fault = 32'h600; ea_fault = 32'h6100; is_store = 1'b0;
        msr_in = 32'h0000_0001; pipe_idle = 1'b0;
        start_seq("drain");
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("drain.hold", 32'({busy, stall_req, srr_we, dar_we, msr_we, npc_we}),
                     32'b110000);
        end
        pipe_idle = 1'b1;
        finish_seq("drain", 1'b1, 32'h600, 32'h0000_0001, 32'h6100, 32'h0800_0000,
                   32'h300, 32'h0000_0001);

        // Reset while in VECT: everything clears, request restarts from IDLE
        dsi = 1'b1; pc_fault = 32'h700; ea_fault = 32'h7000; is_store = 1'b1;
        msr_in = 32'h0000_8030;
        start_seq("rst_vect");
        tick();
        tick();
        check_eq("rst_vect.in_vect", 32'({msr_we, npc_we}), 32'd3);
        rst = 1'b1;
        tick();
        check_all_zero("rst_vect");
        check_eq("rst_vect.flag_kept", 32'(dsi), 32'd1);
        rst = 1'b0;
        start_seq("restart");
        finish_seq("restart", 1'b1, 32'h700, 32'h0000_8030, 32'h7000, 32'h0A00_0000,
                   32'h300, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
